// File: rtl/qdiv_pkg.sv
// Shared definitions for the Q-format divider and its normalisation sequencer.
package qdiv_pkg;

    localparam int QDIV_N = 32;
    localparam int QDIV_Q = 15;

    // Symmetric saturation: the negative limit is -(2^(N-1)-1), not the most negative code.
    localparam logic [QDIV_N-1:0] SAT_POS = {1'b0, {(QDIV_N-1){1'b1}}};
    localparam logic [QDIV_N-1:0] SAT_NEG = {1'b1, {(QDIV_N-2){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        OUT       = 3'd4
    } state_t;

endpackage

// File: rtl/qdiv_norm_sequencer.sv
// Feeds a stream of ELEMS dividends through one qdiv against a common divisor and emits saturated results.
// One element in flight; output held under i_out_ready=0; divide-by-zero bypasses the divider.
module qdiv_norm_sequencer
    import qdiv_pkg::*;
#(
    parameter int N     = QDIV_N,
    parameter int Q     = QDIV_Q,
    parameter int ELEMS = 10
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_divisor,
    input  logic         i_divisor_load,
    input  logic [N-1:0] i_in_data,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    output logic [N-1:0] o_div_dividend,
    output logic [N-1:0] o_div_divisor,
    output logic         o_div_start,
    input  logic [N-1:0] i_div_quotient,
    input  logic         i_div_complete,
    input  logic         i_div_overflow,
    output logic [N-1:0] o_out_data,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic         o_out_last,
    output logic         o_busy,
    output logic         o_div_by_zero
);

    localparam int CW = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(ELEMS - 1);
    localparam logic [N-1:0] SAT_P = (N == QDIV_N) ? N'(SAT_POS) : {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SAT_N = (N == QDIV_N) ? N'(SAT_NEG) : {1'b1, {(N-2){1'b0}}, 1'b1};

    // The fractional position only matters to the divider; it must still leave an integer bit.
    if (Q >= N) begin : g_q_out_of_range
    end

    state_t        state_q;
    logic [CW-1:0] count_q;
    logic [N-1:0]  divisor_q;
    logic [N-1:0]  dividend_q;
    logic          sign_q;
    logic [N-1:0]  result_q;
    logic          in_ready_q;
    logic          start_q;
    logic          out_valid_q;
    logic          out_last_q;
    logic          busy_q;
    logic          dbz_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            divisor_q   <= '0;
            dividend_q  <= '0;
            sign_q      <= 1'b0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            start_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_divisor_load) begin
                        divisor_q <= i_divisor;
                        dbz_q     <= 1'b0;
                    end else if (i_in_valid) begin
                        dividend_q <= i_in_data;
                        sign_q     <= i_in_data[N-1] ^ divisor_q[N-1];
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (divisor_q == '0) begin
                            if (i_in_data == '0) begin
                                result_q <= '0;
                            end else begin
                                result_q <= (i_in_data[N-1] ^ divisor_q[N-1]) ? SAT_N : SAT_P;
                            end
                            dbz_q       <= 1'b1;
                            out_valid_q <= 1'b1;
                            out_last_q  <= (count_q == LAST_IDX);
                            state_q     <= OUT;
                        end else begin
                            start_q <= 1'b1;
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    start_q <= 1'b0;
                    state_q <= WAIT_ACK;
                end
                // complete dropping is the divider's acknowledgement of our start.
                WAIT_ACK: begin
                    if (!i_div_complete) begin
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (i_div_complete) begin
                        result_q    <= i_div_overflow ? (sign_q ? SAT_N : SAT_P) : i_div_quotient;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (count_q == LAST_IDX);
                        state_q     <= OUT;
                    end
                end
                OUT: begin
                    if (i_out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        count_q     <= (count_q == LAST_IDX) ? '0 : count_q + 1'b1;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_in_ready     = in_ready_q;
    assign o_div_dividend = dividend_q;
    assign o_div_divisor  = divisor_q;
    assign o_div_start    = start_q;
    assign o_out_data     = result_q;
    assign o_out_valid    = out_valid_q;
    assign o_out_last     = out_last_q;
    assign o_busy         = busy_q;
    assign o_div_by_zero  = dbz_q;

endmodule

// File: doc/qdiv_norm_sequencer.md
Name: qdiv_norm_sequencer

Overview:
- Upstream driver and downstream collector for the iterative signed Q-format divider (qdiv) in the CNN output path.
- Takes a stream of ELEMS fixed-point values, for example the 10 class scores, and divides each by one common divisor, as in score normalisation.
- Issues one divider start per element and waits on the divider's done/overflow handshake.
- Saturates bad results and emits a valid/ready output stream with a last flag.

Parameters:
- N, 32, word width of dividend, divisor and quotient (two's complement)
- Q, 15, fractional bits; must match the qdiv instance
- ELEMS, 10, elements per frame; o_out_last marks the final one

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_divisor  in  N  common divisor, sampled when i_divisor_load=1
- i_divisor_load  in  1  load divisor; ignored unless state is IDLE
- i_in_data  in  N  dividend element
- i_in_valid  in  1  input valid
- o_in_ready  out  1  input ready
- o_div_dividend  out  N  to qdiv i_dividend; held stable from ISSUE until WAIT_DONE exits
- o_div_divisor  out  N  to qdiv i_divisor; held stable, same window
- o_div_start  out  1  one-cycle start pulse to qdiv
- i_div_quotient  in  N  from qdiv o_quotient_out
- i_div_complete  in  1  from qdiv o_complete; high when idle or done
- i_div_overflow  in  1  from qdiv o_overflow
- o_out_data  out  N  normalised result
- o_out_valid  out  1  output valid
- i_out_ready  in  1  output ready
- o_out_last  out  1  high with element ELEMS-1
- o_busy  out  1  high when state is not IDLE
- o_div_by_zero  out  1  sticky; cleared by reset or divisor load

Behaviour:
- Reset (async, any state including mid-division):
  - state=IDLE, element count=0, divisor register=0.
  - All outputs 0, except o_in_ready=1.
  - A divider still running is ignored; its completion is not sampled until a new ISSUE.
- Handshakes:
  - Input transfer when i_in_valid and o_in_ready are both high.
  - Output transfer when o_out_valid and i_out_ready are both high.
  - o_out_data/o_out_last stay stable while o_out_valid=1 and i_out_ready=0.
- IDLE: o_in_ready=1.
  - A load takes priority over a same-cycle input transfer; that input is not accepted that cycle.
  - Transfer: latch dividend; compute sign = dividend[N-1] ^ divisor[N-1].
  - If divisor==0, go to OUT with the bypass result. Otherwise go to ISSUE.
- ISSUE: 1 cycle; o_div_start=1, o_in_ready=0. Go to WAIT_ACK.
- WAIT_ACK: wait for i_div_complete=0, i.e. the divider accepted the start. Go to WAIT_DONE.
- WAIT_DONE: on i_div_complete=1, capture the result, go to OUT.
  - i_div_overflow=1: result = sign ? 0x80000001 : 0x7FFFFFFF (for N=32).
  - Otherwise: result = i_div_quotient.
- OUT: o_out_valid=1; o_out_last=1 when count==ELEMS-1.
  - On transfer: count increments, wrapping ELEMS-1 -> 0; go to IDLE.
- Divide-by-zero bypass: divider is not started; o_div_by_zero set.
  - Dividend 0: result 0.
  - Otherwise: result 0x7FFFFFFF if sign=0, 0x80000001 if sign=1.
- Latency: o_out_valid rises exactly 1 cycle after the WAIT_DONE cycle that samples i_div_complete=1. Bypass path: input transfer to o_out_valid is 1 cycle.
- Throughput: one element in flight; a new input is accepted only in IDLE.
- Frame boundary: after last, count=0. A divisor load mid-frame (legal only in IDLE) does not reset count.

Decomposition:
- Shared package qdiv_pkg:
  - N/Q defaults
  - SAT_POS = {1'b0,{N-1{1'b1}}}, SAT_NEG = {1'b1,{N-2{1'b0}},1'b1}
  - state enum IDLE/ISSUE/WAIT_ACK/WAIT_DONE/OUT (3-bit)
- No sub-module; the qdiv instance lives in the parent. The bench instantiates both with matching N/Q.

Test Plan:
- Divisor 0x00010000 (2.0), dividend 0x00018000 (3.0) -> o_out_data=0x0000C000 (1.5); exactly one o_div_start pulse; latency as specified.
- Same divisor, dividend 0xFFFE8000 (-3.0) -> 0xFFFF4000 (-1.5).
- Divisor 0x00000001, dividend 0x40000000 -> qdiv overflow -> 0x7FFFFFFF; same with dividend 0xC0000000 -> 0x80000001.
- Divisor 0, dividend 0x00008000 -> 0x7FFFFFFF after 1 cycle; o_div_by_zero=1; o_div_start never pulses; next i_divisor_load clears the flag.
- 10 elements with i_out_ready toggling 0/1 -> data held under stall; o_out_last only on the 10th; count wraps and the 11th is not last.
- Assert i_rst_n=0 during WAIT_DONE -> outputs zero immediately; after release, a new element completes correctly.
